// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op classification for alu_seq.
// Honours ALU_SEQ_DIV_EN: when undefined, DIVU/REMU are not multi-cycle.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLL  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_DIVU = 4'hC;
  localparam logic [3:0] OP_REMU = 4'hD;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // True for ops that run through the iterative unit.
  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative unit: shift-add multiply and (ALU_SEQ_DIV_EN) restoring divide.
// One bit per cycle for W cycles; res is the value produced by the current
// step so the top can register it on the same edge that done is seen.
module alu_iter
  import alu_pkg::*;
#(
  parameter int W   = 16,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic         is_rem,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         run,
  output logic         done,
  output logic [W-1:0] res
);

  // acc: product accumulator (MUL) / partial remainder (DIV)
  // sreg: multiplier shifting out (MUL) / dividend out, quotient in (DIV)
  // opnd: multiplicand shifting up (MUL) / divisor (DIV)
  logic [W-1:0]   acc, sreg, opnd;
  logic [W-1:0]   acc_nxt, sreg_nxt, opnd_nxt;
  logic [SHW-1:0] cnt;

`ifdef ALU_SEQ_DIV_EN
  logic       mode_div, mode_rem;
  logic [W:0] part, trial;
`else
  logic iter_unused;
  assign iter_unused = ^{is_div, is_rem};
`endif

  assign done = run && (cnt == SHW'(W - 1));

  // Operand load on start, one iteration step per cycle while running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      sreg <= '0;
      opnd <= '0;
      cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
      mode_div <= 1'b0;
      mode_rem <= 1'b0;
`endif
    end else if (start) begin
      acc <= '0;
      cnt <= '0;
`ifdef ALU_SEQ_DIV_EN
      mode_div <= is_div;
      mode_rem <= is_rem;
      sreg     <= is_div ? a : b;
      opnd     <= is_div ? b : a;
`else
      sreg <= b;
      opnd <= a;
`endif
    end else if (run) begin
      acc  <= acc_nxt;
      sreg <= sreg_nxt;
      opnd <= opnd_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  // Single step of the selected algorithm
  always_comb begin
    acc_nxt  = acc + (sreg[0] ? opnd : '0);
    sreg_nxt = sreg >> 1;
    opnd_nxt = opnd << 1;
    res      = acc_nxt;
`ifdef ALU_SEQ_DIV_EN
    // part < 2*divisor, so W+1 bits hold it and trial[W] is the borrow
    part  = {acc, sreg[W-1]};
    trial = part - {1'b0, opnd};
    if (mode_div) begin
      opnd_nxt = opnd;
      if (!trial[W]) begin
        acc_nxt  = trial[W-1:0];
        sreg_nxt = {sreg[W-2:0], 1'b1};
      end else begin
        acc_nxt  = part[W-1:0];
        sreg_nxt = {sreg[W-2:0], 1'b0};
      end
      res = mode_rem ? acc_nxt : sreg_nxt;
    end
`endif
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops registered in one stage,
// MUL (and DIVU/REMU when ALU_SEQ_DIV_EN is defined) iterate for W cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W   = 16,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         div0
);

  logic [1:0]     state, state_nxt;
  logic           xfer, start, dz, iter_run, iter_done;
  logic [W-1:0]   sc_res, iter_res;
  logic [SHW-1:0] sh;

  // in_ready depends only on state and out_ready, never on in_valid
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign xfer      = in_valid && in_ready;
  assign sh        = b[SHW-1:0];

`ifdef ALU_SEQ_DIV_EN
  // Divide by zero short-circuits the iteration and completes in one cycle
  assign dz       = ((op == OP_DIVU) || (op == OP_REMU)) && (b == '0);
  assign iter_run = (state == ST_MUL) || (state == ST_DIV);
`else
  assign dz       = 1'b0;
  assign iter_run = (state == ST_MUL);
`endif
  assign start = xfer && is_multicycle(op) && !dz;

  alu_iter #(.W(W), .SHW(SHW)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div ((op == OP_DIVU) || (op == OP_REMU)),
    .is_rem (op == OP_REMU),
    .a      (a),
    .b      (b),
    .run    (iter_run),
    .done   (iter_done),
    .res    (iter_res)
  );

  // Single-cycle datapath; illegal codes fall through to zero
  always_comb begin
    sc_res = '0;
    case (op)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_SLL:  sc_res = a << sh;
      OP_SRL:  sc_res = a >> sh;
      OP_SRA:  sc_res = $unsigned($signed(a) >>> sh);
      OP_XOR:  sc_res = a ^ b;
      OP_SLT:  sc_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_res = {{(W-1){1'b0}}, a < b};
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU: sc_res = '1;
      OP_REMU: sc_res = a;
`endif
      default: sc_res = '0;
    endcase
  end

  // Next-state: accept from IDLE or straight out of DONE, iterate, drain
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (xfer) begin
          if (!start)
            state_nxt = ST_DONE;
`ifdef ALU_SEQ_DIV_EN
          else if (op != OP_MUL)
            state_nxt = ST_DIV;
`endif
          else
            state_nxt = ST_MUL;
        end else if ((state == ST_DONE) && out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: if (iter_done) state_nxt = ST_DONE;
    endcase
  end

  // FSM state register; reset discards any in-flight op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Output register: loads on single-cycle accept or last iteration only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
      div0   <= 1'b0;
    end else if (xfer && !start) begin
      result <= sc_res;
      div0   <= dz;
    end else if (iter_done) begin
      result <= iter_res;
      div0   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed test-plan cases, backpressure,
// streaming, reset mid-MUL and randomized ops against a behavioural model.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, div0;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour straight from the op definitions
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic dz, output int lat);
    int sx, sy, amt;
    sx  = $signed(x);
    sy  = $signed(y);
    amt = int'(y % W);
    r   = '0;
    dz  = 1'b0;
    lat = 1;
    case (o)
      4'h0: r = W'(int'(x) + int'(y));
      4'h1: r = W'(int'(x) - int'(y));
      4'h2: r = x & y;
      4'h3: r = x | y;
      4'h4: r = W'(longint'(x) * (longint'(1) << amt));
      4'h5: r = W'(int'(x) / (1 << amt));
      4'h6: r = W'(sx >>> amt);
      4'h7: r = x ^ y;
      4'h8: r = (sx < sy) ? W'(1) : W'(0);
      4'h9: r = (int'(x) < int'(y)) ? W'(1) : W'(0);
      4'hA: begin r = W'(longint'(x) * longint'(y)); lat = W + 1; end
`ifdef ALU_SEQ_DIV_EN
      4'hC: if (y == 0) begin r = '1; dz = 1'b1; end else begin r = x / y; lat = W + 1; end
      4'hD: if (y == 0) begin r = x;  dz = 1'b1; end else begin r = x % y; lat = W + 1; end
`endif
      default: r = '0;
    endcase
  endtask

  // Issue one op, measure latency, count in_ready highs while busy, consume
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic d, output int lat, output int rdy_busy);
    int g;
    g = 0;
    rdy_busy = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_busy++;
      @(negedge clk);
      lat++;
    end
    r = result;
    d = div0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r, er;
    logic d, ed;
    int lat, elat, busy;
    model(o, x, y, er, ed, elat);
    run_op(o, x, y, r, d, lat, busy);
    chk({tag, ".res"}, 32'(r), 32'(er));
    chk({tag, ".div0"}, 32'(d), 32'(ed));
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    if (elat > 1) chk({tag, ".busy_rdy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_q [8];
    int seen;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result",    32'(result),    32'd0);
    chk("rst.div0",      32'(div0),      32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Directed test-plan cases
    check_op("mul7x6",   4'hA, 16'd7,    16'd6);
    check_op("mulffff",  4'hA, 16'hFFFF, 16'hFFFF);
    check_op("divu",     4'hC, 16'd100,  16'd7);
    check_op("remu",     4'hD, 16'd100,  16'd7);
    check_op("divu0",    4'hC, 16'd5,    16'd0);
    check_op("remu0",    4'hD, 16'd5,    16'd0);
    check_op("sra",      4'h6, 16'h8000, 16'h0013);
    check_op("slt",      4'h8, 16'hFFFF, 16'd1);
    check_op("sltu",     4'h9, 16'hFFFF, 16'd1);
    check_op("sub_wrap", 4'h1, 16'd0,    16'd1);
    check_op("add_wrap", 4'h0, 16'hFFFF, 16'd2);
    check_op("illegalB", 4'hB, 16'h1234, 16'h5678);
    check_op("illegalF", 4'hF, 16'h1234, 16'h5678);

    // Backpressure: result held, in_ready low, then accept-on-drain
    op = 4'h0; a = 16'd3; b = 16'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp.hold_res", 32'(result),   32'd7);
      chk("bp.hold_rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; op = 4'h7; a = 16'h00F0; b = 16'h000F; in_valid = 1'b1;
    #1;
    chk("bp.rdy_on_drain", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp.next_valid", 32'(out_valid), 32'd1);
    chk("bp.next_res",   32'(result),    32'h00FF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Streaming: 8 ADDs, one result per cycle
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("stream.valid", 32'(out_valid), 32'd1);
        chk("stream.res",   32'(result),    32'(exp_q[i-1]));
      end
      out_ready = 1'b1;
      if (i < 8) begin
        op = 4'h0; a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
        exp_q[i] = W'(int'(a) + int'(b));
        #1;
        chk("stream.rdy", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("stream.end", 32'(out_valid), 32'd0);

    // Reset mid-MUL: nothing stale may surface afterwards
    op = 4'hA; a = 16'd7; b = 16'd6; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid.valid",  32'(out_valid), 32'd0);
    chk("rstmid.result", 32'(result),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid.rdy", 32'(in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rstmid.no_stale", 32'(seen), 32'd0);

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 40));
        default: rb = W'($urandom);
      endcase
      check_op("rand", ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
